// File: rtl/main_mem_responder.sv
// Single-outstanding line memory responder: captures a request, waits LATENCY cycles, then answers.
// Define MEM_RANGE_CHECK_EN to flag out-of-range line indices with rsp_err; otherwise the index wraps.
module main_mem_responder #(
  parameter int LINE_DEPTH = 256,
  parameter int LATENCY    = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_rdata,
  output logic         rsp_err
);

  localparam int          AW       = (LINE_DEPTH > 1) ? $clog2(LINE_DEPTH) : 1;
  localparam logic [27:0] DEPTH_W  = 28'(LINE_DEPTH);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [27:0]  line_q, line_d;
  logic [127:0] wdata_q, wdata_d;
  logic         err_q, err_d;
  logic [127:0] rdata_q;
  logic [127:0] mem_q [LINE_DEPTH];

  logic [AW-1:0] mem_addr;
  logic          oob;
  logic          access;
  logic          rsp_done;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_addr[3:0];

`ifdef MEM_RANGE_CHECK_EN
  assign oob      = (line_q >= DEPTH_W);
  assign mem_addr = AW'(line_q);
`else
  assign oob      = 1'b0;
  assign mem_addr = AW'(line_q % DEPTH_W);
`endif

  // The access edge is the last WAIT cycle; reset on that same edge cancels it.
  assign access   = reset && (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign rsp_done = (state_q == ST_RESP) && rsp_ready;

  assign req_ready = reset && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    line_d  = line_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          line_d  = req_addr[31:4];
          wdata_d = req_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          err_d   = oob;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Captured request fields need no reset: they are only consumed after a fresh capture.
  always_ff @(posedge CLOCK_50) begin
    we_q    <= we_d;
    line_q  <= line_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (access && we_q && !oob) begin
      mem_q[mem_addr] <= wdata_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (access) begin
      rdata_q <= (we_q || oob) ? '0 : mem_q[mem_addr];
    end else if (rsp_done) begin
      rdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomised bench for main_mem_responder against a transaction-level model; a LATENCY=1 instance checks throughput.
module tb_main_mem_responder;
  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         req_ready, rsp_valid, rsp_err;
  logic [127:0] rsp_rdata;

  logic         l1_req_valid = 1'b0, l1_req_we = 1'b0, l1_rsp_ready = 1'b0;
  logic [31:0]  l1_req_addr = '0;
  logic [127:0] l1_req_wdata = '0;
  logic         l1_req_ready, l1_rsp_valid, l1_rsp_err;
  logic [127:0] l1_rsp_rdata;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  bit check_en = 1'b0;

  main_mem_responder #(.LINE_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .CLOCK_50(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  main_mem_responder #(.LINE_DEPTH(16), .LATENCY(1)) dut_l1 (
    .CLOCK_50(clk), .reset(rst_n),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_we(l1_req_we),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_rdata(l1_rsp_rdata), .rsp_err(l1_rsp_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // Transaction model: a request is due LAT edges after acceptance, then held until rsp_ready.
  logic [127:0] mmem [DEPTH];
  bit           m_busy = 1'b0, m_resp = 1'b0, m_we = 1'b0, m_err = 1'b0;
  int           m_due = 0;
  int unsigned  m_line = 0, m_idx = 0;
  logic [127:0] m_wdata = '0, m_rdata = '0;

  always @(posedge clk) begin
    edge_no++;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  = 1'b1;
        m_due   = edge_no + LAT;
        m_we    = req_we;
        m_line  = req_addr[31:4];
        m_wdata = req_wdata;
      end
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_busy = 1'b0;
        m_resp = 1'b0;
      end
    end else if (edge_no == m_due) begin
      m_resp  = 1'b1;
      m_err   = 1'b0;
      m_rdata = '0;
`ifdef MEM_RANGE_CHECK_EN
      if (m_line >= DEPTH) m_err = 1'b1;
      else if (m_we) mmem[m_line] = m_wdata;
      else m_rdata = mmem[m_line];
`else
      m_idx = m_line % DEPTH;
      if (m_we) mmem[m_idx] = m_wdata;
      else m_rdata = mmem[m_idx];
`endif
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("req_ready", 128'(req_ready), 128'(rst_n && !m_busy));
      chk("rsp_valid", 128'(rsp_valid), 128'(m_resp));
      chk("rsp_rdata", rsp_rdata, m_resp ? m_rdata : 128'h0);
      chk("rsp_err", 128'(rsp_err), 128'(m_resp && m_err));
    end
  end

  int           l1_resp_edge [$];
  logic [127:0] l1_resp_data [$];
  always @(negedge clk) begin
    if (check_en && l1_rsp_valid) begin
      l1_resp_edge.push_back(edge_no);
      l1_resp_data.push_back(l1_rsp_rdata);
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit we, input logic [31:0] addr, input logic [127:0] data, input int hold,
                       output int lat, output logic [127:0] rdata, output logic err);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("ready_wait", 128'(n < 50), 128'(1));
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
    rsp_ready = (hold == 0);
    tick();
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom; req_wdata = rnd128();
    lat = 0;
    while (!rsp_valid && lat < 50) begin tick(); lat++; end
    chk("latency", 128'(lat), 128'(LAT));
    rdata = rsp_rdata;
    err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = $urandom_range(0, 1); req_we = $urandom_range(0, 1); req_addr = $urandom;
      tick();
    end
    if (hold > 0) chk("hold_stable", rsp_rdata, rdata);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] d, a, p, q, rd;
    logic         er;
    int           lat, n;
    int           acc [12];
    logic [127:0] l1_exp [6];

    repeat (3) tick();
    check_en = 1'b1;
    chk("reset_req_ready", 128'(req_ready), 128'(0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("reset_rsp_rdata", rsp_rdata, 128'h0);
    chk("reset_rsp_err", 128'(rsp_err), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_req_ready", 128'(req_ready), 128'(1));

    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i << 4), rnd128(), 0, lat, rd, er);

    d = 128'h0123456789abcdef0123456789abcdef;
    issue(1'b1, 32'h40, d, 0, lat, rd, er);
    chk("wr_lat", 128'(lat), 128'(4));
    chk("wr_rdata_zero", rd, 128'h0);
    issue(1'b0, 32'h4C, rnd128(), 0, lat, rd, er);
    chk("rd_line4", rd, 128'h0123456789abcdef0123456789abcdef);
    issue(1'b0, 32'h4C, rnd128(), 3, lat, rd, er);
    chk("rd_hold_line4", rd, d);

    // Reset two cycles into a write's WAIT must cancel the store.
    a = 128'haaaa5555aaaa5555aaaa5555aaaa5555;
    issue(1'b1, 32'h50, a, 0, lat, rd, er);
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wdata = ~a;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) n++;
      tick();
    end
    chk("rst_no_rsp", 128'(n), 128'(0));
    issue(1'b0, 32'h50, rnd128(), 0, lat, rd, er);
    chk("rst_prior_data", rd, 128'haaaa5555aaaa5555aaaa5555aaaa5555);

    p = 128'h11111111222222223333333344444444;
    q = 128'h99999999888888887777777766666666;
    issue(1'b1, 32'h0, p, 0, lat, rd, er);
    issue(1'b1, 32'h1000, q, 0, lat, rd, er);
`ifdef MEM_RANGE_CHECK_EN
    chk("oob_err", 128'(er), 128'(1));
`else
    chk("oob_err", 128'(er), 128'(0));
`endif
    issue(1'b0, 32'h0, rnd128(), 0, lat, rd, er);
`ifdef MEM_RANGE_CHECK_EN
    chk("oob_line0", rd, 128'h11111111222222223333333344444444);
`else
    chk("oob_line0", rd, 128'h99999999888888887777777766666666);
`endif

    for (int t = 0; t < 120; t++) begin
      int line;
      line = ($urandom_range(0, 99) < 85) ? $urandom_range(0, 15) : $urandom_range(256, 271);
      issue($urandom_range(0, 1), {4'h0, 24'(line), 4'($urandom)}, rnd128(),
            $urandom_range(0, 3), lat, rd, er);
      repeat ($urandom_range(0, 2)) tick();
    end

    // LATENCY=1 instance: requests held back-to-back, one accepted every third cycle.
    l1_req_valid = 1'b1;
    l1_rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      l1_req_we = (k < 6);
      l1_req_addr = 32'((k % 6) << 4);
      if (k < 6) begin
        l1_exp[k] = rnd128();
        l1_req_wdata = l1_exp[k];
      end else begin
        l1_req_wdata = rnd128();
      end
      n = 0;
      while (!l1_req_ready && n < 10) begin tick(); n++; end
      chk("l1_ready_wait", 128'(n < 10), 128'(1));
      @(posedge clk);
      #1;
      acc[k] = edge_no;
      l1_req_addr = $urandom;
      l1_req_wdata = rnd128();
    end
    l1_req_valid = 1'b0;
    repeat (4) tick();
    chk("l1_count", 128'(l1_resp_edge.size()), 128'(12));
    for (int k = 0; k < 12 && k < l1_resp_edge.size(); k++) begin
      chk("l1_rsp_edge", 128'(l1_resp_edge[k]), 128'(acc[k] + 1));
      if (k > 0) chk("l1_spacing", 128'(acc[k] - acc[k-1]), 128'(3));
      chk("l1_rdata", l1_resp_data[k], (k < 6) ? 128'h0 : l1_exp[k-6]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
